// File: rtl/uart_rx_if.sv
// Serial receive interface: line input plus received-byte and status strobes.
// The receiver takes the slave side; the line driver and consumer take the master side.
`timescale 1ns/1ps

interface uart_rx_if #(
  parameter int DATA_BITS = 8
);

  logic                 i_rxd;        // async serial line, idle high
  logic [DATA_BITS-1:0] o_data;       // last good byte, held until the next good frame
  logic                 o_valid;      // 1-cycle pulse: o_data updated this cycle
  logic                 o_frame_err;  // 1-cycle pulse: stop bit sampled low
  logic                 o_busy;       // receiver is inside a frame

  modport master (
    output i_rxd,
    input  o_data,
    input  o_valid,
    input  o_frame_err,
    input  o_busy
  );

  modport slave (
    input  i_rxd,
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_busy
  );

endinterface

// File: rtl/uart_rx.sv
// UART receiver for 8N1-style frames on an oversampling clock.
// Synchronises the line, detects the start edge, samples each bit at mid-bit
// and reports the byte (o_valid) or a bad stop bit (o_frame_err) as 1-cycle strobes.
`timescale 1ns/1ps

module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic     i_clk_rx,
  input  logic     i_reset,
  uart_rx_if.slave bus
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  // Reject configurations the mid-bit sampling scheme cannot support.
  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
    $error("uart_rx: OVERSAMPLE must be even and >= 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  // Synchroniser chain and edge-detect flop.
  logic rxd_meta_q;
  logic rxd_s_q;
  logic rxd_d_q;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [IDX_W-1:0]     idx_q,   idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q,  data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q,  ferr_d;

  // Two-flop synchroniser on the async line plus one delay flop for falling-edge detection.
  // NOTE: reset these to the idle level (1) so leaving reset never looks like a start edge.
  always_ff @(posedge i_clk_rx) begin
    if (!i_reset) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_d_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
      rxd_meta_q <= bus.i_rxd;
      rxd_s_q    <= rxd_meta_q;
      rxd_d_q    <= rxd_s_q;
    end
  end

  // Frame state, counters, shift register and registered outputs.
  always_ff @(posedge i_clk_rx) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: find the start edge, confirm it at half a bit, then sample each
  // following bit one full bit period later, i.e. at its centre.
  always_comb begin
    // NOTE: every target gets a default first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Only a high-to-low transition starts a frame; a line stuck low stays idle.
        if (rxd_d_q && !rxd_s_q) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rxd_s_q) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            // Line went back high before mid-bit: treat as a glitch, silently.
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxd_s_q;
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          // Leaving here at mid stop bit keeps half a bit of margin for a back-to-back start.
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rxd_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = ferr_q;
  assign bus.o_busy      = (state_q != ST_IDLE);

endmodule
